// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-SRAM arbiter.
package ifetch_pkg;

  localparam int unsigned ISRAM_AW       = 14;
  localparam int unsigned STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FET,
    OWN_LS_RD,
    OWN_LS_WR
  } resp_own_e;

endpackage

// File: rtl/isram_arb.sv
// Single-port instruction SRAM arbiter: fetch vs. load/store, load/store priority with
// a starvation limit for fetch, 1-cycle read latency tracked by a registered owner tag.
module isram_arb
  import ifetch_pkg::*;
#(
  parameter int unsigned AW         = ISRAM_AW,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fet_req,
  input  logic [31:0]   fet_addr,
  input  logic          fet_flush,
  output logic          fet_gnt,
  output logic          fet_rvalid,
  output logic [63:0]   fet_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [31:0]   ls_addr,
  input  logic [63:0]   ls_wdata,
  input  logic [7:0]    ls_wmask,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [63:0]   ls_rdata,
  output logic          isram_cs,
  output logic          isram_we,
  output logic [AW-1:0] isram_addr,
  output logic [63:0]   isram_wdata,
  output logic [7:0]    isram_wem,
  input  logic [63:0]   isram_rdata,
  output logic          lr_isram_cs
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  resp_own_e   resp_own_q, resp_own_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic        starve_hit;
  logic        fet_ok;
  logic [31:0] gnt_addr;
  logic        unused_addr;

  assign starve_hit = (starve_cnt_q == CW'(STARVE_MAX));

  // A flushed fetch request never reaches the SRAM, even when it is owed the slot.
  always_comb begin
    fet_ok   = fet_req & ~fet_flush & ~rst;
    fet_gnt  = fet_ok & (~ls_req | starve_hit);
    ls_gnt   = ls_req & ~rst & ~fet_gnt;
    isram_cs = fet_gnt | ls_gnt;
    gnt_addr = ls_gnt ? ls_addr : fet_addr;
    isram_addr  = gnt_addr[AW+2:3];
    isram_we    = ls_gnt & ls_we;
    isram_wdata = ls_wdata;
    isram_wem   = isram_we ? ls_wmask : 8'h00;
  end

  assign unused_addr = ^{gnt_addr[2:0], gnt_addr[31:AW+3]};

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (rst || fet_gnt || !fet_req) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_comb begin
    resp_own_d = OWN_NONE;
    if (!rst) begin
      if (fet_gnt) begin
        resp_own_d = OWN_FET;
      end else if (ls_gnt) begin
        resp_own_d = ls_we ? OWN_LS_WR : OWN_LS_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_own_q   <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      resp_own_q   <= resp_own_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    fet_rvalid  = (resp_own_q == OWN_FET) & ~fet_flush;
    ls_rvalid   = (resp_own_q == OWN_LS_RD);
    lr_isram_cs = (resp_own_q == OWN_LS_RD) | (resp_own_q == OWN_LS_WR);
    fet_rdata   = isram_rdata;
    ls_rdata    = isram_rdata;
  end

endmodule

// File: tb/tb_isram_arb.sv
// Directed vector bench for isram_arb: a table of per-cycle stimulus/expectations,
// then hand-written starvation and reset-during-read sequences.
module tb_isram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fet_req = 1'b0, fet_flush = 1'b0;
  logic [31:0] fet_addr = '0;
  logic        fet_gnt, fet_rvalid;
  logic [63:0] fet_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [63:0] ls_wdata = '0;
  logic [7:0]  ls_wmask = '0;
  logic        ls_gnt, ls_rvalid;
  logic [63:0] ls_rdata;
  logic        isram_cs, isram_we;
  logic [13:0] isram_addr;
  logic [63:0] isram_wdata;
  logic [7:0]  isram_wem;
  logic [63:0] isram_rdata = '0;
  logic        lr_isram_cs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  isram_arb #(.AW(14), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .fet_req(fet_req), .fet_addr(fet_addr), .fet_flush(fet_flush),
    .fet_gnt(fet_gnt), .fet_rvalid(fet_rvalid), .fet_rdata(fet_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .isram_cs(isram_cs), .isram_we(isram_we), .isram_addr(isram_addr),
    .isram_wdata(isram_wdata), .isram_wem(isram_wem), .isram_rdata(isram_rdata),
    .lr_isram_cs(lr_isram_cs)
  );

  typedef struct {
    logic        rst, fet_req, fet_flush, ls_req, ls_we;
    logic [31:0] fet_addr, ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        e_fgnt, e_lgnt, e_frv, e_lrv, e_lr;
    logic [13:0] e_addr;
  } vec_t;

  function automatic vec_t mk(logic r, logic fr, logic [31:0] fa, logic ff, logic lq,
                              logic lw, logic [31:0] la, logic [63:0] wd, logic [7:0] wm,
                              logic efg, logic elg, logic efr, logic elr, logic elc,
                              logic [13:0] ea);
    vec_t v;
    v.rst = r; v.fet_req = fr; v.fet_addr = fa; v.fet_flush = ff;
    v.ls_req = lq; v.ls_we = lw; v.ls_addr = la; v.ls_wdata = wd; v.ls_wmask = wm;
    v.e_fgnt = efg; v.e_lgnt = elg; v.e_frv = efr; v.e_lrv = elr; v.e_lr = elc;
    v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fr, input logic [31:0] fa, input logic ff,
                       input logic lq, input logic lw, input logic [31:0] la,
                       input logic [63:0] wd, input logic [7:0] wm, input logic [63:0] rd);
    @(negedge clk);
    rst = r; fet_req = fr; fet_addr = fa; fet_flush = ff;
    ls_req = lq; ls_we = lw; ls_addr = la; ls_wdata = wd; ls_wmask = wm;
    isram_rdata = rd;
    #2;
  endtask

  // Checks everything whose expectation follows from grants, owner tag and stimulus.
  task automatic check_cycle(input string tag, input logic efg, input logic elg,
                             input logic efr, input logic elr, input logic elc,
                             input logic [13:0] ea);
    chk({tag, ".fet_gnt"}, 64'(fet_gnt), 64'(efg));
    chk({tag, ".ls_gnt"}, 64'(ls_gnt), 64'(elg));
    chk({tag, ".isram_cs"}, 64'(isram_cs), 64'(efg | elg));
    chk({tag, ".fet_rvalid"}, 64'(fet_rvalid), 64'(efr));
    chk({tag, ".ls_rvalid"}, 64'(ls_rvalid), 64'(elr));
    chk({tag, ".lr_isram_cs"}, 64'(lr_isram_cs), 64'(elc));
    chk({tag, ".isram_we"}, 64'(isram_we), 64'(elg & ls_we));
    chk({tag, ".isram_wem"}, 64'(isram_wem), (elg & ls_we) ? 64'(ls_wmask) : 64'h0);
    if (efg | elg) chk({tag, ".isram_addr"}, 64'(isram_addr), 64'(ea));
    if (elg & ls_we) chk({tag, ".isram_wdata"}, isram_wdata, ls_wdata);
    if (efr) chk({tag, ".fet_rdata"}, fet_rdata, isram_rdata);
    if (elr) chk({tag, ".ls_rdata"}, ls_rdata, isram_rdata);
  endtask

  vec_t vecs[$];
  logic exp_f[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    //            rst fr fa            ff lq lw la            wdata                  wm
    //            efg elg efr elr elc  addr
    vecs.push_back(mk(1, 1, 32'h100, 0, 1, 0, 32'h2000, 64'h0, 8'h00, 0, 0, 0, 0, 0, 14'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 0, 0, 0, 0, 0, 14'h0));
    vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 32'h0, 64'h0, 8'h00, 1, 0, 0, 0, 0, 14'h20));
    vecs.push_back(mk(0, 1, 32'h108, 0, 0, 0, 32'h0, 64'h0, 8'h00, 1, 0, 1, 0, 0, 14'h21));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 0, 0, 1, 0, 0, 14'h0));
    vecs.push_back(mk(0, 1, 32'h200, 0, 1, 0, 32'h2000, 64'h0, 8'h00, 0, 1, 0, 0, 0, 14'h400));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 0, 0, 0, 1, 1, 14'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 1, 32'h18, 64'h1122334455667788, 8'h0F,
                      0, 1, 0, 0, 0, 14'h3));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 0, 0, 0, 0, 1, 14'h0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0, 32'h0, 64'h0, 8'h00, 1, 0, 0, 0, 0, 14'h8));
    vecs.push_back(mk(0, 1, 32'h48, 1, 0, 0, 32'h0, 64'h0, 8'h00, 0, 0, 0, 0, 0, 14'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 0, 0, 0, 0, 0, 14'h0));
    vecs.push_back(mk(0, 1, 32'hFFFF0007, 0, 0, 0, 32'h0, 64'h0, 8'h00, 1, 0, 0, 0, 0, 14'h2000));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 0, 32'h2008, 64'h0, 8'h00, 0, 1, 1, 0, 0, 14'h401));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 0, 0, 0, 1, 1, 14'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fet_req, vecs[i].fet_addr, vecs[i].fet_flush,
            vecs[i].ls_req, vecs[i].ls_we, vecs[i].ls_addr, vecs[i].ls_wdata,
            vecs[i].ls_wmask, 64'hA5A5_0000_0000_0000 | 64'(i));
      check_cycle($sformatf("vec%0d", i), vecs[i].e_fgnt, vecs[i].e_lgnt, vecs[i].e_frv,
                  vecs[i].e_lrv, vecs[i].e_lr, vecs[i].e_addr);
    end

    // Starvation: both requesters held for 5 cycles -> ls, ls, ls, fet, ls.
    for (int c = 0; c < 5; c++) begin
      logic prev_f, prev_l;
      prev_f = (c > 0) && exp_f[c-1];
      prev_l = (c > 0) && !exp_f[c-1];
      drive(0, 1, 32'h80, 0, 1, 0, 32'h1000, 64'h0, 8'h00, 64'h5500 | 64'(c));
      check_cycle($sformatf("starve%0d", c), exp_f[c], !exp_f[c], prev_f, prev_l, prev_l,
                  exp_f[c] ? 14'h10 : 14'h200);
    end
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 64'h77);
    check_cycle("starve_tail", 0, 0, 0, 1, 1, 14'h0);

    // Reset right after a load grant, with the counter already at its limit.
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 32'h80, 0, 1, 0, 32'h1000, 64'h0, 8'h00, 64'h0);
      check_cycle($sformatf("pre_rst%0d", c), 0, 1, 0, c > 0, c > 0, 14'h200);
    end
    drive(1, 1, 32'h80, 0, 1, 0, 32'h1000, 64'h0, 8'h00, 64'h0);
    chk("rst.fet_gnt", 64'(fet_gnt), 64'h0);
    chk("rst.ls_gnt", 64'(ls_gnt), 64'h0);
    chk("rst.isram_cs", 64'(isram_cs), 64'h0);
    // Counter must be back at 0, so load/store wins again instead of the fetch.
    drive(0, 1, 32'h80, 0, 1, 0, 32'h1000, 64'h0, 8'h00, 64'h0);
    check_cycle("post_rst", 0, 1, 0, 0, 0, 14'h200);
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 64'h0, 8'h00, 64'h99);
    check_cycle("post_rst_tail", 0, 0, 0, 1, 1, 14'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/isram_arb.md
ISRAM_ARB -- requirements
Module: isram_arb

Interface
REQ-001 SHALL have parameter AW, default 14: isram word-address width; each word is 64 bits.
REQ-002 SHALL have parameter STARVE_MAX, default 3: maximum consecutive load/store grants while a fetch waits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have fet_req input 1 (fetch request) and fet_addr input 32 (fetch byte address).
REQ-006 SHALL have fet_flush input 1: pipeline redirect; discard the pending fetch response.
REQ-007 SHALL have fet_gnt output 1, fet_rvalid output 1 and fet_rdata output 64 (fetch grant, fetch read-data valid, fetch read data).
REQ-008 SHALL have ls_req input 1, ls_we input 1 and ls_addr input 32 (load/store request, write enable, byte address).
REQ-009 SHALL have ls_wdata input 64 and ls_wmask input 8 (store data and per-byte write mask).
REQ-010 SHALL have ls_gnt output 1, ls_rvalid output 1 and ls_rdata output 64 (load/store grant, load data valid, load data).
REQ-011 SHALL have isram_cs output 1, isram_we output 1 and isram_addr output AW (SRAM chip select, write enable, word address).
REQ-012 SHALL have isram_wdata output 64, isram_wem output 8 and isram_rdata input 64 (SRAM write data, byte write mask, read data).
REQ-013 SHALL have lr_isram_cs output 1: high when the current isram_rdata belongs to load/store, so fetch alignment logic does not capture it.

Function
REQ-014 SHALL grant at most one requester per cycle, combinationally in the request cycle; isram_cs = fet_gnt | ls_gnt.
REQ-015 SHALL give ls_req priority over fet_req; exception: fet_req wins when starve_cnt == STARVE_MAX.
REQ-016 SHALL suppress a fet_req that is asserted in the same cycle as fet_flush (no fet_gnt, no SRAM access).
REQ-017 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cycle where ls_gnt=1 and fet_req=1 and fet_gnt=0.
REQ-018 starve_cnt SHALL clear on fet_gnt or on any cycle with fet_req=0; otherwise it holds.
REQ-019 SHALL drive isram_addr = granted address[AW+2:3]; address bits [2:0] are ignored (sub-word alignment is handled downstream).
REQ-020 On a load/store write grant SHALL drive isram_we=1, isram_wdata=ls_wdata, isram_wem=ls_wmask.
REQ-021 In all other cycles SHALL drive isram_we=0 and isram_wem=0.
REQ-022 SHALL keep a registered response owner resp_own in {NONE, FET, LS_RD, LS_WR}, set from the grant of the previous cycle, NONE if there was no grant.
REQ-023 Read latency SHALL be 1 cycle: fet_rvalid = (resp_own==FET) & ~fet_flush; ls_rvalid = (resp_own==LS_RD).
REQ-024 fet_rdata and ls_rdata SHALL both pass isram_rdata through unregistered; their values are don't-care when the matching rvalid is low.
REQ-025 SHALL assert lr_isram_cs = (resp_own==LS_RD) | (resp_own==LS_WR).
REQ-026 Stores SHALL produce no ls_rvalid; completion is signalled by ls_gnt alone.
REQ-027 Back-to-back grants to either requester, and alternating grants, SHALL be fully pipelined with no bubble cycles.
REQ-028 Requesters SHALL hold req, addr and data stable until the grant; the arbiter keeps no request queue.

Reset
REQ-029 While rst=1 at a clock edge: resp_own=NONE and starve_cnt=0.
REQ-030 Grants SHALL be forced to 0 in any cycle where rst=1.
REQ-031 The cycle after reset release, all outputs except the rdata pass-through are 0; any read in flight when reset asserted is dropped.

Structure
REQ-032 Package ifetch_pkg SHALL hold the resp_own enum (OWN_NONE, OWN_FET, OWN_LS_RD, OWN_LS_WR) and the default AW and STARVE_MAX constants.
REQ-033 SHALL be a single module with no sub-modules; starve counter, grant logic and response tracking are all inline.

Verification
REQ-034 Fetch only: fet_req=1, fet_addr=0x100 and 0x108 on consecutive cycles -> isram_addr 0x20 then 0x21; fet_rvalid on the two following cycles; lr_isram_cs=0.
REQ-035 Collision: fet_req and ls_req (load, ls_addr=0x2000) in the same cycle, starve_cnt=0 -> ls_gnt=1, fet_gnt=0; next cycle ls_rvalid=1 and lr_isram_cs=1.
REQ-036 Starvation: fet_req held with ls_req held for 5 cycles, STARVE_MAX=3 -> ls granted 3 cycles, fet_gnt in the 4th, ls granted in the 5th.
REQ-037 Store: ls_we=1, ls_wmask=0x0F, ls_wdata=0x1122334455667788 -> isram_we=1 and isram_wem=0x0F that cycle; no ls_rvalid; lr_isram_cs=1 the next cycle.
REQ-038 Flush: fet_flush=1 in the cycle after a fetch grant -> fet_rvalid=0; a fet_req in that same cycle receives no grant.
REQ-039 Reset mid-read: rst=1 in the cycle after a load grant -> ls_rvalid=0 and lr_isram_cs=0 the following cycle; starve_cnt=0.
